spi_frame_receiver: RTL
=======================

// Module: spi_frame_receiver
// PURPOSE
//  Receives SPI mode-0 write frames (SCLK, COPI, nCS on ui_in[0..2]) in the system clock domain.
//  Synchronises the pins, deserialises 16-bit frames and emits one write strobe per valid frame.
//  Sits directly upstream of the register bank that drives the PWM enable/duty registers.
//  Rejects malformed, read or out-of-range frames and flags them.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop depth of each pin synchroniser (>=2)
//  FRAME_BITS   16  bits per frame: [15]=R/W (1=write), [14:8]=addr, [7:0]=data
//  MAX_ADDR     4   highest accepted register address (0x00..0x04)
// PORTS
//  clk         in   1  system clock; all logic on posedge
//  rst         in   1  asynchronous, active-high reset
//  sclk        in   1  raw SPI clock (async to clk)
//  copi        in   1  raw SPI data in, MSB first
//  ncs         in   1  raw chip select, active low
//  wr_valid    out  1  one-cycle strobe: wr_addr/wr_data valid
//  wr_addr     out  7  register address of accepted write
//  wr_data     out  8  register data of accepted write
//  frame_err   out  1  one-cycle strobe: frame had wrong bit count or bad address
//  busy        out  1  high while synchronised ncs is low
// BEHAVIOUR
//  Reset: wr_valid=0, wr_addr=0, wr_data=0, frame_err=0, busy=0, state=IDLE, bit_cnt=0, shift=0.
//  Reset is asynchronous; asserting it mid-frame aborts the frame with no strobes.
//  All three pins pass through SYNC_STAGES FFs; edge detection uses one extra FF per pin.
//  FSM: IDLE -> ACTIVE on synced ncs fall; ACTIVE -> CHECK on synced ncs rise; CHECK -> IDLE always.
//  IDLE: bit_cnt cleared, sclk edges ignored.
//  ACTIVE: on each synced sclk rise: shift={shift[14:0],copi_sync}; bit_cnt+=1, saturating at FRAME_BITS+1.
//  CHECK (exactly one cycle), decision made from shift and bit_cnt:
//   - bit_cnt==0                                  -> no strobe (empty select)
//   - bit_cnt!=FRAME_BITS                         -> frame_err=1
//   - shift[15]==0 (read)                         -> no strobe, silently dropped
//   - shift[14:8]>MAX_ADDR                        -> frame_err=1
//   - otherwise                                   -> wr_valid=1, wr_addr=shift[14:8], wr_data=shift[7:0]
//  Strobes are registered; they are high in the cycle after CHECK and low in the next cycle.
//  wr_addr/wr_data hold their last accepted values until the next accepted write.
//  Latency: wr_valid rises SYNC_STAGES+3 clk cycles after the raw ncs rising edge.
//  Simultaneous sclk rise and ncs rise in one clk cycle: the sclk edge is counted first, then CHECK.
//  Frames arriving back-to-back are accepted if ncs stays high for >=2 clk cycles.
//  SCLK high and low phases each >=3 clk cycles (sclk <= clk/6); faster SCLK is unsupported.
//  busy = ~ncs_sync, registered.
// STRUCTURE
//  Shared package spi_defs:
//   - FRAME_BITS, field positions (RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8)
//   - MAX_ADDR and the register address constants 0x00..0x04
//   - FSM state encoding IDLE/ACTIVE/CHECK
//  Sub-module sync_edge_detect (params SYNC_STAGES):
//   - one instance per pin
//   - outputs level, rise and fall
//  Top level holds the FSM, shift register, bit counter and output registers.
// TESTING
//  1 Write 0x80_FF (addr 0, data 0xFF) -> one wr_valid pulse, wr_addr=0x00, wr_data=0xFF, frame_err=0.
//  2 Write 0x84_80 (addr 4, duty 0x80) -> wr_valid, wr_addr=0x04, wr_data=0x80.
//    Latency from ncs rise is SYNC_STAGES+3 cycles.
//  3 Read frame 0x02_55 -> no wr_valid, no frame_err; outputs keep their prior values.
//  4 Write 0x85_11 (addr 5) -> frame_err pulse, no wr_valid.
//  5 Frames of 15 and 17 clocks -> frame_err each. A 0-clock select -> no strobe at all.
//  6 rst asserted after 8 bits, released, then a full write 0x81_AA -> only the second frame strobes
//    (addr 1, data 0xAA).

Source files
------------

// File: rtl/spi_frame_receiver_pkg.sv
// -----------------------------------------------------------------------------
// spi_defs
//   Shared definitions for the SPI write-frame receiver:
//   frame geometry, field positions, accepted register address range and the
//   receiver FSM state encoding.
// -----------------------------------------------------------------------------
package spi_defs;

    // Frame geometry: [15]=R/W (1=write), [14:8]=address, [7:0]=data
    localparam int FRAME_BITS = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int ADDR_W     = ADDR_MSB - ADDR_LSB + 1;
    localparam int DATA_W     = ADDR_LSB;

    // Bit counter must hold FRAME_BITS+1 (its saturation value)
    localparam int CNT_W      = $clog2(FRAME_BITS + 2);

    // Highest accepted register address and the register map
    localparam int MAX_ADDR   = 4;
    localparam logic [ADDR_W-1:0] REG_ADDR_0 = 7'h00;
    localparam logic [ADDR_W-1:0] REG_ADDR_1 = 7'h01;
    localparam logic [ADDR_W-1:0] REG_ADDR_2 = 7'h02;
    localparam logic [ADDR_W-1:0] REG_ADDR_3 = 7'h03;
    localparam logic [ADDR_W-1:0] REG_ADDR_4 = 7'h04;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CHECK  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// -----------------------------------------------------------------------------
// sync_edge_detect
//   Brings one asynchronous pin into the clk domain through a SYNC_STAGES deep
//   flip-flop chain and reports its level plus one-cycle rise/fall strobes.
//   level, rise and fall are all registered together, so in the cycle rise is
//   high, level already shows the new value.
// Ports
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   din    in  raw asynchronous pin
//   level  out synchronised pin level
//   rise   out one-cycle strobe on a synchronised 0->1 transition
//   fall   out one-cycle strobe on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter int   SYNC_STAGES = 2,
    // Idle level of the pin; reset loads it so no edge is seen on release
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   synced;

    assign synced = chain[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            level <= RESET_VAL;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            // level doubles as the edge-detect history flop
            level <= synced;
            rise  <= synced & ~level;
            fall  <= ~synced & level;
        end
    end

endmodule

// File: rtl/spi_frame_receiver.sv
// -----------------------------------------------------------------------------
// spi_frame_receiver
//   Receives SPI mode-0 write frames in the system clock domain and emits one
//   write strobe per valid 16-bit write frame to the downstream register bank.
//   Wrong bit counts and out-of-range addresses raise frame_err; read frames
//   and empty selects are dropped silently.
// Ports
//   clk        in  system clock, all logic on posedge
//   rst        in  asynchronous active-high reset
//   sclk       in  raw SPI clock (asynchronous)
//   copi       in  raw SPI data, MSB first, sampled on sclk rise
//   ncs        in  raw chip select, active low
//   wr_valid   out one-cycle strobe, wr_addr/wr_data valid
//   wr_addr    out address of the last accepted write (held)
//   wr_data    out data of the last accepted write (held)
//   frame_err  out one-cycle strobe, bad bit count or bad address
//   busy       out high while the synchronised ncs is low
// Handshake: wr_valid is a single-cycle push with no back-pressure; the
// consumer must take wr_addr/wr_data in the cycle wr_valid is high.
// The FSM state is kept in the named signal 'state' for observation.
// -----------------------------------------------------------------------------
module spi_frame_receiver
    import spi_defs::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic copi_level, copi_rise, copi_fall;
    logic ncs_level,  ncs_rise,  ncs_fall;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   shift;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk   (clk),
        .rst   (rst),
        .din   (copi),
        .level (copi_level),
        .rise  (copi_rise),
        .fall  (copi_fall)
    );

    // ncs idles high, so it resets high to avoid a false select on release
    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk   (clk),
        .rst   (rst),
        .din   (ncs),
        .level (ncs_level),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    // Unused edge strobes, folded so the intent is explicit
    logic unused_edges;
    assign unused_edges = sclk_level ^ sclk_fall ^ copi_rise ^ copi_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= ~ncs_level;

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (ncs_fall) begin
                        state <= ACTIVE;
                    end
                end

                ACTIVE: begin
                    // An sclk edge coinciding with deselect is still counted;
                    // CHECK sees the updated shift/bit_cnt one cycle later.
                    if (sclk_rise) begin
                        shift <= {shift[FRAME_BITS-2:0], copi_level};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    if (ncs_rise) begin
                        state <= CHECK;
                    end
                end

                CHECK: begin
                    state <= IDLE;
                    if (bit_cnt == '0) begin
                        // empty select: nothing to report
                    end else if (bit_cnt != CNT_FULL) begin
                        frame_err <= 1'b1;
                    end else if (!shift[RW_BIT]) begin
                        // read request: this block only handles writes
                    end else if (shift[ADDR_MSB:ADDR_LSB] > ADDR_W'(MAX_ADDR)) begin
                        frame_err <= 1'b1;
                    end else begin
                        wr_valid <= 1'b1;
                        wr_addr  <= shift[ADDR_MSB:ADDR_LSB];
                        wr_data  <= shift[DATA_W-1:0];
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
